// File: rtl/cpu_pkg.sv
// cpu_pkg: shared controller state type and default MDU latency
package cpu_pkg;
  typedef enum logic {RUN, MDU_WAIT} ctrl_state_t;
  localparam int MDU_LATENCY_DEF = 32;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous active-high reset
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
  end
endmodule

// File: rtl/pipeline_controller.sv
// pipeline_controller: prioritised stall/flush sequencing for the 5-stage pipeline with MDU wait FSM
module pipeline_controller
  import cpu_pkg::*;
#(
  parameter int MDU_LATENCY = MDU_LATENCY_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hz_stall,
  input  logic             branch_taken,
  input  logic             mdu_start,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             ID_EX_Write,
  output logic             EX_MEM_Write,
  output logic             MEM_WB_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Flush,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_count
);
  localparam int CW = $clog2(MDU_LATENCY + 1);
  // {PC, IF_ID, ID_EX, EX_MEM, MEM_WB writes, IF_ID, ID_EX, EX_MEM flushes}
  localparam logic [7:0] C_DEF = 8'b11111_000;
  localparam logic [7:0] C_RST = 8'b00000_111;
  localparam logic [7:0] C_FRZ = 8'b00000_000;
  localparam logic [7:0] C_MDU = 8'b00011_001;
  localparam logic [7:0] C_BR  = 8'b11111_110;
  localparam logic [7:0] C_LU  = 8'b00111_010;
  ctrl_state_t   r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [7:0]    w_ctl;
  logic          w_freeze;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end
  always_comb begin
    w_freeze   = mem_req && !mem_ready;
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_ctl      = C_DEF;
    if (reset) w_ctl = C_RST;
    else if (r_state == MDU_WAIT) begin
      // countdown continues through freezes but parks at zero until the release can happen
      w_cnt_next = (r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
      if (w_freeze) w_ctl = C_FRZ;
      else if (r_cnt != '0) w_ctl = C_MDU;
      else w_next = RUN;
    end else if (w_freeze) w_ctl = C_FRZ;
    else if (mdu_start) begin
      w_ctl      = C_MDU;
      w_cnt_next = CW'(MDU_LATENCY - 1);
      w_next     = MDU_WAIT;
    end else if (branch_taken) w_ctl = C_BR;
    else if (hz_stall) w_ctl = C_LU;
  end
  assign {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write,
          IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush} = w_ctl;
  assign mdu_busy = (r_state == MDU_WAIT) && !reset;
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!reset && !PCWrite),
    .count (stall_count)
  );
endmodule
